bin2bcd_seq: RTL and testbench

Sequential binary-to-packed-BCD converter that sits directly upstream of the six-digit multiplexed seven-segment display driver. It accepts a 20-bit unsigned binary value on a start pulse and converts it with a shift-and-add-3 (double-dabble) iteration, one bit per clock. It then presents a stable 24-bit packed-BCD word, six nibbles, that connects straight to the display driver's `num` input. Values above 999999 saturate the display to 999999 and raise an overflow flag.

---
 rtl/bin2bcd_seq_if.sv | 24 ++
 rtl/bin2bcd_seq.sv | 107 ++++++++++
 tb/tb_bin2bcd_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Handshake and data bundle between a conversion requester and bin2bcd_seq.
// The requester drives start/bin; the converter returns the packed-BCD result
// together with its status flags.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
    logic                  done;
    logic                  ovf;

    modport master (
        output start, bin,
        input  bcd, busy, done, ovf
    );

    modport slave (
        input  start, bin,
        output bcd, busy, done, ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter (double dabble, one bit per clock).
// The visible result register only changes on the done edge, so the display
// driver downstream never sees a partially converted value. Inputs above
// 10^DIGITS-1 saturate to all nines and raise ovf.
module bin2bcd_seq #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [BIN_W-1:0] MAX_VAL  = BIN_W'(10**DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [BIN_W-1:0]    sr_q;        // remaining binary bits, MSB first
    logic [BCD_W-1:0]    scratch_q;   // BCD digits being built up
    logic [BCD_W-1:0]    adj;         // scratch after the add-3 correction
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_pend_q;  // overflow decision for the running conversion
    logic [BCD_W-1:0]    bcd_q;
    logic                done_q;
    logic                ovf_q;

    // Add 3 to every digit that is 5 or more so the following doubling carries
    // correctly into the next decimal digit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
    end

    // Next-state logic: one conversion runs IDLE -> SHIFT x BIN_W -> DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registers are written with non-blocking assignments so every
        // flop samples the values from before the edge, independent of order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath: capture on start, shift one bit per SHIFT cycle, publish on DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q       <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sr_q       <= bus.bin;
                        scratch_q  <= '0;
                        cnt_q      <= '0;
                        ovf_pend_q <= (bus.bin > MAX_VAL);
                    end
                end
                SHIFT: begin
                    scratch_q <= {adj[BCD_W-2:0], sr_q[BIN_W-1]};
                    sr_q      <= {sr_q[BIN_W-2:0], 1'b0};
                    cnt_q     <= cnt_q + 1'b1;
                end
                DONE: begin
                    bcd_q  <= ovf_pend_q ? {DIGITS{4'h9}} : scratch_q;
                    ovf_q  <= ovf_pend_q;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.bcd  = bcd_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and random checks of bin2bcd_seq: latency, result, saturation,
// start-while-busy, reset abort and result stability between done pulses.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst;

    bin2bcd_seq_if #(.BIN_W(20), .DIGITS(6)) bus ();

    bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] exp_hold = '0;   // result the bench expects to be on bcd right now
    logic        ovf_hold = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] ref_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned x;
        if (v > 999999) return 24'h999999;
        r = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Called just after an edge; the start pulse is accepted on the next edge.
    task automatic start_conv(input logic [19:0] b);
        bus.start = 1'b1;
        bus.bin   = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.bin   = 20'hABCDE;   // later bin changes must not disturb the conversion
    endtask

    // Wait for done, checking that bcd/ovf hold and busy stays high meanwhile.
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            check({tag, "_hold_bcd"}, bus.bcd, exp_hold);
            check({tag, "_hold_ovf"}, bus.ovf, ovf_hold);
            check({tag, "_busy"}, bus.busy, 1'b1);
            @(posedge clk); #1;
            lat++;
        end
        if (bus.done !== 1'b1) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic expect_conv(input string tag, input logic [23:0] exp_bcd,
                               input logic exp_ovf, input int exp_lat);
        int lat;
        wait_done(tag, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_bcd"}, bus.bcd, exp_bcd);
        check({tag, "_ovf"}, bus.ovf, exp_ovf);
        check({tag, "_busy_off"}, bus.busy, 1'b0);
        for (int i = 0; i < 6; i++)
            check({tag, "_digit"}, (bus.bcd[4*i +: 4] <= 4'd9), 1'b1);
        exp_hold = exp_bcd;
        ovf_hold = exp_ovf;
    endtask

    task automatic conv(input string tag, input logic [19:0] b,
                        input logic [23:0] exp_bcd, input logic exp_ovf);
        start_conv(b);
        expect_conv(tag, exp_bcd, exp_ovf, 21);
    endtask

    // Expect no done pulse for n cycles.
    task automatic quiet(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int unsigned v;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bcd",  bus.bcd,  24'h0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_ovf",  bus.ovf,  1'b0);
        rst = 1'b0;

        // Normal conversion; bcd must stay 0 until done.
        conv("norm", 20'd123456, 24'h123456, 1'b0);
        @(posedge clk); #1;
        check("done_one_cycle", bus.done, 1'b0);

        // Boundaries without overflow.
        conv("zero", 20'd0,      24'h000000, 1'b0);
        conv("max",  20'd999999, 24'h999999, 1'b0);
        conv("nine", 20'd9,      24'h000009, 1'b0);
        conv("ten",  20'd10,     24'h000010, 1'b0);

        // Overflow and clearing of the flag.
        conv("ovf_1m",   20'd1000000, 24'h999999, 1'b1);
        conv("ovf_full", 20'hFFFFF,   24'h999999, 1'b1);
        conv("ovf_clr",  20'd42,      24'h000042, 1'b0);

        // Second start during the conversion is ignored.
        start_conv(20'd111111);
        repeat (4) begin
            @(posedge clk); #1;
        end
        bus.start = 1'b1;
        bus.bin   = 20'd222222;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.bin   = '0;
        expect_conv("busy_ign", 24'h111111, 1'b0, 16);
        // Start during the done cycle is accepted.
        conv("b2b", 20'd333333, 24'h333333, 1'b0);
        quiet("no_extra_done", 25);

        // Reset mid-conversion, with start asserted alongside rst.
        start_conv(20'd654321);
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.bin   = 20'd5;
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_bcd",  bus.bcd,  24'h0);
        check("abort_done", bus.done, 1'b0);
        check("abort_ovf",  bus.ovf,  1'b0);
        exp_hold = '0;
        ovf_hold = 1'b0;
        quiet("abort_no_done", 25);
        check("abort_idle_bcd", bus.bcd, 24'h0);
        conv("after_rst", 20'd7, 24'h000007, 1'b0);

        // Random sweep, back to back.
        for (int n = 0; n < 1000; n++) begin
            v = $urandom_range(0, 20'hFFFFF);
            conv("sweep", 20'(v), ref_bcd(v), (v > 999999));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
